// File: rtl/neuron_tdm_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// neuron_pkg : shared types and constants for the TDM neuron scheduler
// Rev 1.0
// ============================================================================
package neuron_pkg;

    localparam int DATA_W = 21;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_RS = 2'd0;
    localparam logic [1:0] MODE_CH = 2'd1;
    localparam logic [1:0] MODE_FS = 2'd2;
    localparam logic [1:0] MODE_IB = 2'd3;

    localparam logic [DATA_W-1:0] V_INIT = 21'h1F6000;
    localparam logic [DATA_W-1:0] U_INIT = 21'h1FE000;

    function automatic logic [DATA_W-1:0] mode_c(input logic [1:0] mode);
        case (mode)
            MODE_CH: mode_c = 21'h1F9000;
            MODE_IB: mode_c = 21'h1F8600;
            default: mode_c = 21'h1F6000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] mode_d(input logic [1:0] mode);
        case (mode)
            MODE_CH: mode_d = 21'h000980;
            MODE_FS: mode_d = 21'h000E80;
            MODE_IB: mode_d = 21'h001100;
            default: mode_d = 21'h001E00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_tdm_scheduler_if.sv
`default_nettype none
// ============================================================================
// neuron_tdm_scheduler_if : request/response link between scheduler and core
// Rev 1.0
// ============================================================================
interface neuron_tdm_scheduler_if #(
    parameter int W = 21
);
    logic         core_start;
    logic [W-1:0] core_v;
    logic [W-1:0] core_u;
    logic [W-1:0] core_I;
    logic [W-1:0] core_c;
    logic [W-1:0] core_d;
    logic         core_done;
    logic [W-1:0] core_v_nxt;
    logic [W-1:0] core_u_nxt;
    logic         core_spike;

    modport master (
        output core_start, core_v, core_u, core_I, core_c, core_d,
        input  core_done, core_v_nxt, core_u_nxt, core_spike
    );

    modport slave (
        input  core_start, core_v, core_u, core_I, core_c, core_d,
        output core_done, core_v_nxt, core_u_nxt, core_spike
    );
endinterface
`default_nettype wire

// File: rtl/neuron_tdm_scheduler_state_rf.sv
`default_nettype none
// ============================================================================
// neuron_state_rf : per-neuron v/u storage, init write overrides writeback
// Rev 1.0
// ============================================================================
module neuron_state_rf
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IDXW      = 2,
    parameter int W         = DATA_W
) (
    input  wire logic            clk,
    input  wire logic            set,
    input  wire logic            wr_en_i,
    input  wire logic [IDXW-1:0] wr_idx_i,
    input  wire logic [W-1:0]    wr_v_i,
    input  wire logic [W-1:0]    wr_u_i,
    input  wire logic            init_en_i,
    input  wire logic [IDXW-1:0] init_idx_i,
    input  wire logic [IDXW-1:0] rd_idx_i,
    output logic      [W-1:0]    rd_v_o,
    output logic      [W-1:0]    rd_u_o
);

    logic [W-1:0] v_q [N_NEURONS];
    logic [W-1:0] u_q [N_NEURONS];

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_entry
        always_ff @(posedge clk or negedge set) begin
            if (!set) begin
                v_q[i] <= W'(V_INIT);
                u_q[i] <= W'(U_INIT);
            end else if (init_en_i && (init_idx_i == IDXW'(i))) begin
                v_q[i] <= W'(V_INIT);
                u_q[i] <= W'(U_INIT);
            end else if (wr_en_i && (wr_idx_i == IDXW'(i))) begin
                v_q[i] <= wr_v_i;
                u_q[i] <= wr_u_i;
            end
        end
    end

    assign rd_v_o = v_q[rd_idx_i];
    assign rd_u_o = u_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/neuron_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// neuron_tdm_scheduler : shares one Izhikevich core across N virtual neurons
// Rev 1.0
// ============================================================================
module neuron_tdm_scheduler
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IDXW      = 2,
    parameter int W         = DATA_W
) (
    input  wire logic                 clk,
    input  wire logic                 set,
    input  wire logic                 step_start,
    output logic                      busy,
    output logic                      step_done,
    output logic      [N_NEURONS-1:0] spike_vec,
    input  wire logic                 cfg_we,
    input  wire logic [IDXW-1:0]      cfg_idx,
    input  wire logic [1:0]           cfg_mode,
    input  wire logic [W-1:0]         cfg_I,
    input  wire logic                 cfg_init,
    neuron_tdm_scheduler_if.master    core
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [N_NEURONS-1:0]   acc_q, acc_d;
    logic [N_NEURONS-1:0]   spike_vec_q;

    logic [W-1:0]           op_v_q, op_u_q, op_i_q, op_c_q, op_d_q;
    logic [W-1:0]           res_v_q, res_u_q;
    logic                   res_spk_q;

    logic [1:0]             mode_q [N_NEURONS];
    logic [W-1:0]           cur_q  [N_NEURONS];

    logic [W-1:0]           rf_v, rf_u;
    logic                   load_op;

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_cfg
        always_ff @(posedge clk or negedge set) begin
            if (!set) begin
                mode_q[i] <= MODE_RS;
                cur_q[i]  <= '0;
            end else if (cfg_we && (cfg_idx == IDXW'(i))) begin
                mode_q[i] <= cfg_mode;
                cur_q[i]  <= cfg_I;
            end
        end
    end

    // Read port follows the next index so operands are in place on entry to ISSUE
    neuron_state_rf #(
        .N_NEURONS (N_NEURONS),
        .IDXW      (IDXW),
        .W         (W)
    ) u_state_rf (
        .clk        (clk),
        .set        (set),
        .wr_en_i    (state_q == ST_WB),
        .wr_idx_i   (idx_q),
        .wr_v_i     (res_v_q),
        .wr_u_i     (res_u_q),
        .init_en_i  (cfg_we && cfg_init),
        .init_idx_i (cfg_idx),
        .rd_idx_i   (idx_d),
        .rd_v_o     (rf_v),
        .rd_u_o     (rf_u)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (step_start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core.core_done) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                acc_d[idx_q] = res_spk_q;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_op = (state_d == ST_ISSUE);

    always_ff @(posedge clk or negedge set) begin
        if (!set) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            spike_vec_q <= '0;
            op_v_q      <= '0;
            op_u_q      <= '0;
            op_i_q      <= '0;
            op_c_q      <= '0;
            op_d_q      <= '0;
            res_v_q     <= '0;
            res_u_q     <= '0;
            res_spk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            if (load_op) begin
                op_v_q <= rf_v;
                op_u_q <= rf_u;
                op_i_q <= cur_q[idx_d];
                op_c_q <= W'(mode_c(mode_q[idx_d]));
                op_d_q <= W'(mode_d(mode_q[idx_d]));
            end
            if ((state_q == ST_WAIT) && core.core_done) begin
                res_v_q   <= core.core_v_nxt;
                res_u_q   <= core.core_u_nxt;
                res_spk_q <= core.core_spike;
            end
            // Publish together with step_done so the flags are valid in that cycle
            if (state_d == ST_DONE) begin
                spike_vec_q <= acc_d;
            end
        end
    end

    assign busy            = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_WB);
    assign step_done       = (state_q == ST_DONE);
    assign spike_vec       = spike_vec_q;
    assign core.core_start = (state_q == ST_ISSUE);
    assign core.core_v     = op_v_q;
    assign core.core_u     = op_u_q;
    assign core.core_I     = op_i_q;
    assign core.core_c     = op_c_q;
    assign core.core_d     = op_d_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// tb_neuron_tdm_scheduler : directed bench with an in-bench core and model
// Rev 1.0
// ============================================================================
module tb_neuron_tdm_scheduler;
    import neuron_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 21;

    logic          clk = 1'b0;
    logic          set = 1'b0;
    logic          step_start = 1'b0;
    logic          busy, step_done;
    logic [N-1:0]  spike_vec;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_I = '0;
    logic          cfg_init = 1'b0;

    int errors = 0;
    int checks = 0;

    neuron_tdm_scheduler_if #(.W(DW)) core_bus ();

    neuron_tdm_scheduler #(.N_NEURONS(N), .IDXW(IW), .W(DW)) dut (
        .clk        (clk),
        .set        (set),
        .step_start (step_start),
        .busy       (busy),
        .step_done  (step_done),
        .spike_vec  (spike_vec),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_mode   (cfg_mode),
        .cfg_I      (cfg_I),
        .cfg_init   (cfg_init),
        .core       (core_bus)
    );

    always #5 clk = ~clk;

    // Behavioural state of every virtual neuron plus the core's planned answers
    logic [DW-1:0] m_v [N];
    logic [DW-1:0] m_u [N];
    logic [DW-1:0] m_I [N];
    logic [1:0]    m_mode [N];
    logic [DW-1:0] rv [N];
    logic [DW-1:0] ru [N];
    logic [N-1:0]  rs;
    logic [DW-1:0] seen_v [N];
    logic [DW-1:0] seen_I [N];
    logic [DW-1:0] seen_c [N];
    logic [DW-1:0] seen_d [N];

    function automatic logic [DW-1:0] tc(input logic [1:0] m);
        case (m)
            2'd1:    tc = 21'h1F9000;
            2'd3:    tc = 21'h1F8600;
            default: tc = 21'h1F6000;
        endcase
    endfunction

    function automatic logic [DW-1:0] td(input logic [1:0] m);
        case (m)
            2'd0:    td = 21'h001E00;
            2'd1:    td = 21'h000980;
            2'd2:    td = 21'h000E80;
            default: td = 21'h001100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            m_v[i] = V_INIT;
            m_u[i] = U_INIT;
            m_I[i] = '0;
            m_mode[i] = 2'd0;
        end
    endtask

    task automatic cfg_write(input int idx, input logic [1:0] mode, input logic [DW-1:0] cur);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_mode = mode; cfg_I = cur; cfg_init = 1'b0;
        m_mode[idx] = mode;
        m_I[idx] = cur;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // One full timestep; the bench plays the core with latency L and checks every cycle
    task automatic run_step(input int L, input bit dup, input int init_wb, input int iwr_wait,
                            input logic [DW-1:0] new_I, input logic [N-1:0] exp_spk);
        int k, wcnt, starts, last_s;
        bit waiting, wbp, done_seen, first;
        logic [DW-1:0] ev, eI;
        k = 0; wcnt = 0; starts = 0; last_s = 0;
        waiting = 0; wbp = 0; done_seen = 0; first = 0;
        ev = '0; eI = '0;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        for (int n = 1; n <= 300 && !done_seen; n++) begin
            core_bus.core_done = 1'b0;
            cfg_we = 1'b0;
            cfg_init = 1'b0;
            step_start = dup && (n == 7);
            if (step_done) begin
                done_seen = 1;
                chk("step_cycles", n, N * (2 + L) + 1);
                chk("core_start_count", starts, N);
                chk("spike_vec", spike_vec, exp_spk);
                chk("busy_in_done", busy, 0);
            end else begin
                chk("busy", busy, 1);
                if (wbp) begin
                    wbp = 0;
                    if (init_wb == k) begin
                        cfg_we = 1'b1; cfg_init = 1'b1; cfg_idx = IW'(k);
                        cfg_mode = m_mode[k]; cfg_I = m_I[k];
                        m_v[k] = V_INIT;
                        m_u[k] = U_INIT;
                    end
                    k++;
                end
                if (waiting) begin
                    chk("hold_operands", {core_bus.core_start, core_bus.core_v, core_bus.core_I},
                        {1'b0, ev, eI});
                    if (first && iwr_wait == k) begin
                        cfg_we = 1'b1; cfg_idx = IW'(k); cfg_mode = m_mode[k]; cfg_I = new_I;
                        m_I[k] = new_I;
                    end
                    first = 0;
                    wcnt--;
                    if (wcnt == 0) begin
                        core_bus.core_done  = 1'b1;
                        core_bus.core_v_nxt = rv[k];
                        core_bus.core_u_nxt = ru[k];
                        core_bus.core_spike = rs[k];
                        m_v[k] = rv[k];
                        m_u[k] = ru[k];
                        waiting = 0;
                        wbp = 1;
                    end
                end
                if (core_bus.core_start) begin
                    chk("operands",
                        {core_bus.core_v, core_bus.core_u, core_bus.core_I, core_bus.core_c, core_bus.core_d},
                        {m_v[k], m_u[k], m_I[k], tc(m_mode[k]), td(m_mode[k])});
                    if (starts > 0) chk("start_gap", n - last_s, 2 + L);
                    seen_v[k] = core_bus.core_v;
                    seen_I[k] = core_bus.core_I;
                    seen_c[k] = core_bus.core_c;
                    seen_d[k] = core_bus.core_d;
                    ev = m_v[k];
                    eI = m_I[k];
                    last_s = n;
                    starts++;
                    waiting = 1;
                    first = 1;
                    wcnt = L;
                end
            end
            @(posedge clk); #1;
        end
        core_bus.core_done = 1'b0;
        step_start = 1'b0;
        cfg_we = 1'b0;
        cfg_init = 1'b0;
        if (!done_seen) chk("step_done_timeout", 0, 1);
        chk("after_done", {step_done, busy, spike_vec}, {1'b0, 1'b0, exp_spk});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        core_bus.core_done  = 1'b0;
        core_bus.core_v_nxt = '0;
        core_bus.core_u_nxt = '0;
        core_bus.core_spike = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy, step_done, core_bus.core_start, spike_vec}, 0);
        chk("reset_ops", {core_bus.core_v, core_bus.core_c, core_bus.core_d}, 0);
        set = 1'b1;
        @(posedge clk); #1;

        // Step 1: L=3, spikes on 1 and 3, redundant step_start mid-step
        rv[0] = 21'h000040; rv[1] = 21'h000080; rv[2] = 21'h000100; rv[3] = 21'h000200;
        ru[0] = 21'h000011; ru[1] = 21'h000022; ru[2] = 21'h000033; ru[3] = 21'h000044;
        rs = 4'b1010;
        run_step(3, 1'b1, -1, -1, '0, 4'b1010);
        chk("first_issue_v", seen_v[0], 21'h1F6000);
        chk("first_issue_cd", {seen_c[0], seen_d[0]}, {21'h1F6000, 21'h001E00});
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_no_restart", {busy, core_bus.core_start}, 0);
        end

        // Step 2: modes RS/CH/FS/IB, L=1, collision init and mid-WAIT I write on idx 2
        cfg_write(0, 2'd0, 21'h000010);
        cfg_write(1, 2'd1, 21'h000020);
        cfg_write(2, 2'd2, 21'h000030);
        cfg_write(3, 2'd3, 21'h000040);
        rv[0] = 21'h000500; rv[1] = 21'h000600; rv[2] = 21'h000700; rv[3] = 21'h000800;
        rs = 4'b0000;
        run_step(1, 1'b0, 2, 2, 21'h000ABC, 4'b0000);
        chk("chain_v2", seen_v[2], 21'h000100);
        chk("mode_d", {seen_d[0], seen_d[1], seen_d[2], seen_d[3]},
            {21'h001E00, 21'h000980, 21'h000E80, 21'h001100});
        chk("mode_c", {seen_c[1], seen_c[3]}, {21'h1F9000, 21'h1F8600});
        chk("old_I2", seen_I[2], 21'h000030);

        // Step 3: L=2, idx 2 was reinitialised and carries the new current
        rs = 4'b0001;
        run_step(2, 1'b0, -1, -1, '0, 4'b0001);
        chk("init_wins_v2", seen_v[2], 21'h1F6000);
        chk("new_I2", seen_I[2], 21'h000ABC);
        chk("chain_v1", seen_v[1], 21'h000600);

        // Asynchronous reset in the middle of WAIT
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        chk("issue_pulse", core_bus.core_start, 1);
        @(posedge clk); #2;
        set = 1'b0;
        #1;
        chk("async_reset_ctrl", {busy, step_done, core_bus.core_start, spike_vec}, 0);
        chk("async_reset_ops", {core_bus.core_v, core_bus.core_c, core_bus.core_d}, 0);
        reset_model();
        repeat (2) @(posedge clk);
        #3;
        set = 1'b1;
        @(posedge clk); #1;
        rs = 4'b0100;
        run_step(2, 1'b0, -1, -1, '0, 4'b0100);
        chk("post_reset_v", seen_v[0], 21'h1F6000);
        chk("post_reset_cd", {seen_c[2], seen_d[2]}, {21'h1F6000, 21'h001E00});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neuron_tdm_scheduler.md
Name: neuron_tdm_scheduler

Overview:
Time-multiplexes one Izhikevich update core (the `main` datapath) across N_NEURONS virtual neurons. The block holds per-neuron state (v, u) and configuration (firing mode, input current I). On each simulation step it issues every neuron to the core in index order and writes the results back. It sits between the host/stimulus logic and the single neuron core, and replaces per-neuron core instances.

Parameters:
N_NEURONS, 4, number of virtual neurons sharing the core (power of 2, ≥2)
IDXW, 2, neuron index width, equal to log2(N_NEURONS)
W, 21, fixed-point datapath width for v, u, I, c, d (two's complement)

Ports:
clk  in  1  system clock, rising-edge
set  in  1  reset, asynchronous, active-low (set=0 resets)
step_start  in  1  one-cycle pulse; begins one timestep across all neurons
busy  out  1  high from the cycle after an accepted step_start until step_done
step_done  out  1  one-cycle pulse when all neurons are written back
spike_vec  out  N_NEURONS  spike flags of the last completed step, bit i = neuron i
cfg_we  in  1  configuration write strobe
cfg_idx  in  IDXW  target neuron for the configuration write
cfg_mode  in  2  firing mode: 0=RS, 1=CH, 2=FS, 3=IB
cfg_I  in  W  input current for the target neuron
cfg_init  in  1  with cfg_we, also reinitialise the target's v/u
core_start  out  1  one-cycle request pulse to the core
core_v  out  W  v operand, held stable from core_start until core_done
core_u  out  W  u operand, held stable
core_I  out  W  I operand, held stable
core_c  out  W  c operand from the mode table, held stable
core_d  out  W  d operand from the mode table, held stable
core_done  in  1  one-cycle pulse; core results valid in the same cycle
core_v_nxt  in  W  updated v
core_u_nxt  in  W  updated u
core_spike  in  1  spike occurred on this update

Behaviour:
- Reset (set=0, asynchronous): FSM=IDLE; busy=0, step_done=0, core_start=0, spike_vec=0, core_* operands=0. For all i: mode=RS, I=0, v=V_INIT (0x1F6000), u=U_INIT.
- FSM states: IDLE, ISSUE, WAIT, WB, DONE.
- IDLE: step_start=1 → ISSUE; idx=0; clear the spike accumulator.
- ISSUE (1 cycle): latch v[idx], u[idx], I[idx], c/d from MODE_TABLE[mode[idx]] onto the core_* operands; core_start=1 → WAIT.
- WAIT: hold all operands; on core_done=1, capture core_v_nxt, core_u_nxt, core_spike → WB. No timeout; core latency is unbounded (≥1 cycle).
- WB (1 cycle): write v[idx], u[idx]; set acc[idx]=core_spike. If idx==N_NEURONS-1 → DONE, else idx++ and → ISSUE.
- DONE (1 cycle): spike_vec ← acc; step_done=1 → IDLE. busy=0 in the same cycle.
- Per-neuron latency: 2 + L cycles, where L is the number of cycles from core_start to core_done. A step takes N_NEURONS·(2+L)+1 cycles after the step_start sample.
- step_start while busy or in DONE: ignored, no queueing.
- core_done outside WAIT: ignored.
- cfg_we: accepted in any state. Mode and I update at the next edge. The in-flight neuron is unaffected because its operands were latched in ISSUE.
- cfg_init=1 with cfg_we: v[cfg_idx]=V_INIT, u[cfg_idx]=U_INIT. If this collides with a WB to the same index in the same cycle, cfg_init wins.
- No arithmetic in this block; all widths pass through unchanged at W bits.

Decomposition:
- Package neuron_pkg holds:
  - FSM state enum.
  - Mode encoding constants.
  - MODE_TABLE c/d values: RS c=0x1F6000 d=0x001E00; CH c=0x1F9000 d=0x000980; FS c=0x1F6000 d=0x000E80; IB c=0x1F8600 d=0x001100.
  - V_INIT and U_INIT.
- One sub-module, neuron_state_rf: N_NEURONS-entry v/u register file with one write port (cfg_init has priority), one read port, and asynchronous reset.

Test Plan:
- Reset: drive set=0 mid-WAIT (L=3) → all outputs 0 immediately, FSM in IDLE; after release, first ISSUE drives core_v=0x1F6000, core_c=0x1F6000, core_d=0x001E00.
- Full step, N=4, core model L=3, spikes on neurons 1 and 3 → core_start pulses 5 cycles apart; step_done at cycle 21 after step_start; spike_vec=4'b1010.
- Mode table: cfg_mode of neurons 0–3 set to RS/CH/FS/IB → successive core_d = 0x001E00, 0x000980, 0x000E80, 0x001100; core_c matches the table.
- Writeback chaining: core returns v_nxt=0x000100 for neuron 2 → on the next step, ISSUE for neuron 2 shows core_v=0x000100.
- step_start during busy → ignored; exactly 4 core_start pulses, one step_done.
- Config collision: cfg_we+cfg_init to idx 2 in neuron 2's WB cycle → next step shows core_v=0x1F6000. cfg_I written to idx 2 while neuron 2 is in WAIT → current operands unchanged, new I seen next step.
